ps2_rx_fifo: RTL and testbench

Parametrised PS/2 device-to-host receiver for the calculator top level. It replaces direct, unbuffered sampling of PS2_CLK/PS2_DATA with four stages: synchronisation, clock-glitch filtering, full 11-bit frame checking (start, 8 data, odd parity, stop) and an inter-edge timeout. Good bytes are queued in a DEPTH-entry FIFO so picoVersat software can read scancodes at its own pace through the parallel interface.

---
 rtl/ps2_rx_fifo_pkg.sv | 25 ++
 rtl/ps2_rx_fifo_sync_fifo.sv | 62 ++++++
 rtl/ps2_rx_fifo.sv | 197 +++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_rx_fifo_pkg.sv
// rtl/ps2_rx_fifo_pkg.sv - shared PS/2 receiver definitions
// Holds the receive FSM state encoding, frame geometry and the odd-parity
// helper used by ps2_rx_fifo. No ports.
package ps2_rx_fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    localparam int PS2_DATA_W     = 8;
    localparam int PS2_START_BITS = 1;
    localparam int PS2_PAR_BITS   = 1;
    localparam int PS2_STOP_BITS  = 1;
    localparam int PS2_FRAME_BITS = PS2_START_BITS + PS2_DATA_W + PS2_PAR_BITS + PS2_STOP_BITS;

    // Odd parity: the data bits together with the parity bit hold an odd
    // number of ones.
    function automatic logic odd_parity_ok(input logic [PS2_DATA_W-1:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_rx_fifo_sync_fifo.sv
// rtl/ps2_rx_fifo_sync_fifo.sv - single-clock show-ahead FIFO
// Ports: clk, rst (async active-low), push/push_data write side,
// pop/pop_data/not_empty read side (pop ignored when empty), full, level.
// A push while full is accepted only if a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     not_empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    // Extra wrap bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; pop_data is forced to zero while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q[AW-1:0]] <= push_data;
    end

    assign pop_data  = empty ? '0 : mem[rd_ptr_q[AW-1:0]];
    assign not_empty = ~empty;
    assign level     = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - filtered PS/2 device-to-host receiver with byte FIFO
// Ports: clk, rst (async active-low); ps2_clk/ps2_data raw pins;
// rd_en/rd_data/rd_valid/level show-ahead FIFO read side;
// par_err/frm_err one-cycle error pulses; ovf sticky overflow, clr_ovf clears.
module ps2_rx_fifo
    import ps2_rx_fifo_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int FILT_LEN    = 8,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ps2_clk,
    input  logic                    ps2_data,
    input  logic                    rd_en,
    output logic [PS2_DATA_W-1:0]   rd_data,
    output logic                    rd_valid,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    par_err,
    output logic                    frm_err,
    output logic                    ovf,
    input  logic                    clr_ovf
);

    localparam int FCNT_W = $clog2(FILT_LEN + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);

    // Synchroniser; idle-high reset value avoids a false edge after reset.
    logic clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data;
            dat_s2_q <= dat_s1_q;
        end
    end

    // Glitch filter: a run of FILT_LEN samples differing from the filtered
    // value flips it; any sample agreeing with it restarts the run.
    logic              filt_q, filt_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              fall_q, fall_d;

    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (clk_s2_q != filt_q) begin
            if (fcnt_q == FCNT_W'(FILT_LEN - 1)) filt_d = clk_s2_q;
            else                                 fcnt_d = fcnt_q + 1'b1;
        end
        fall_d = filt_q & ~filt_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt_q <= 1'b1;
            fcnt_q <= '0;
            fall_q <= 1'b0;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
            fall_q <= fall_d;
        end
    end

    // Frame FSM and inter-edge timeout.
    ps2_state_e            state_q, state_d;
    logic [2:0]            bitcnt_q, bitcnt_d;
    logic [PS2_DATA_W-1:0] shreg_q, shreg_d;
    logic                  par_ok_q, par_ok_d;
    logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
    logic                  push_q, push_d;
    logic                  par_err_q, par_err_d;
    logic                  frm_err_q, frm_err_d;

    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        shreg_d   = shreg_q;
        par_ok_d  = par_ok_q;
        to_cnt_d  = to_cnt_q;
        push_d    = 1'b0;
        par_err_d = 1'b0;
        frm_err_d = 1'b0;
        if (fall_q) begin
            to_cnt_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (!dat_s2_q) begin
                        state_d  = ST_DATA;
                        bitcnt_d = '0;
                    end
                end
                ST_DATA: begin
                    shreg_d  = {dat_s2_q, shreg_q[PS2_DATA_W-1:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = ST_PARITY;
                end
                ST_PARITY: begin
                    par_ok_d = odd_parity_ok(shreg_q, dat_s2_q);
                    state_d  = ST_STOP;
                end
                default: begin
                    // A bad stop bit is a framing error whatever the parity.
                    if (dat_s2_q) begin
                        if (par_ok_q) push_d    = 1'b1;
                        else          par_err_d = 1'b1;
                    end else begin
                        frm_err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            endcase
        end else if (state_q != ST_IDLE) begin
            if (to_cnt_q == TO_W'(TIMEOUT_CYC)) begin
                state_d   = ST_IDLE;
                frm_err_d = 1'b1;
                to_cnt_d  = '0;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end else begin
            to_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            bitcnt_q  <= '0;
            shreg_q   <= '0;
            par_ok_q  <= 1'b0;
            to_cnt_q  <= '0;
            push_q    <= 1'b0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            shreg_q   <= shreg_d;
            par_ok_q  <= par_ok_d;
            to_cnt_q  <= to_cnt_d;
            push_q    <= push_d;
            par_err_q <= par_err_d;
            frm_err_q <= frm_err_d;
        end
    end

    assign par_err = par_err_q;
    assign frm_err = frm_err_q;

    // Byte queue; shreg_q is stable during the push cycle because no
    // strobe can follow the stop strobe that quickly.
    logic fifo_full;
    logic drop;
    logic ovf_q, ovf_d;

    sync_fifo #(
        .WIDTH (PS2_DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_q),
        .push_data (shreg_q),
        .pop       (rd_en),
        .pop_data  (rd_data),
        .not_empty (rd_valid),
        .full      (fifo_full),
        .level     (level)
    );

    assign drop = push_q & fifo_full & ~(rd_en & rd_valid);

    // A new overflow wins over a coincident clear.
    always_comb begin
        ovf_d = ovf_q;
        if (drop)         ovf_d = 1'b1;
        else if (clr_ovf) ovf_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ovf_q <= 1'b0;
        else      ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - scoreboard bench for ps2_rx_fifo
module tb_ps2_rx_fifo;

    localparam int DEPTH       = 4;
    localparam int FILT_LEN    = 8;
    localparam int TIMEOUT_CYC = 300;
    localparam int HALF        = 40;
    localparam int LVL_W       = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             ps2_clk = 1'b1;
    logic             ps2_data = 1'b1;
    logic             rd_en = 1'b0;
    logic             clr_ovf = 1'b0;
    logic [7:0]       rd_data;
    logic             rd_valid;
    logic [LVL_W-1:0] level;
    logic             par_err;
    logic             frm_err;
    logic             ovf;

    ps2_rx_fifo #(
        .DEPTH       (DEPTH),
        .FILT_LEN    (FILT_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .level    (level),
        .par_err  (par_err),
        .frm_err  (frm_err),
        .ovf      (ovf),
        .clr_ovf  (clr_ovf)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_q[$];
    logic       model_ovf = 1'b0;
    int         exp_par = 0;
    int         exp_frm = 0;

    int   par_cnt = 0, frm_cnt = 0, both_cnt = 0, wide_cnt = 0;
    logic par_prev = 1'b0, frm_prev = 1'b0;

    always @(negedge clk) begin
        if (par_err && frm_err) both_cnt++;
        if (par_err && !par_prev) par_cnt++;
        if (frm_err && !frm_prev) frm_cnt++;
        if ((par_err && par_prev) || (frm_err && frm_prev)) wide_cnt++;
        par_prev = par_err;
        frm_prev = frm_err;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives bits[0..nbits-1] LSB first, data changing in the high phase.
    task automatic send_bits(input logic [10:0] bits, input int nbits,
                             input int glitch_at, input int glitch_len, input bit pop_at_push);
        logic [7:0] head;
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            if (i == glitch_at) begin
                tick(10);
                ps2_clk = 1'b0;
                tick(glitch_len);
                ps2_clk = 1'b1;
                tick(HALF - 10 - glitch_len);
            end else begin
                tick(HALF);
            end
            ps2_clk = 1'b0;
            if (pop_at_push && i == nbits - 1) begin
                // Land the pop on the same edge as the internal push.
                tick(FILT_LEN + 3);
                head = exp_q.pop_front();
                check("pop_at_push_valid", rd_valid, 1);
                check("pop_at_push_data", rd_data, head);
                rd_en = 1'b1;
                tick(1);
                rd_en = 1'b0;
                tick(HALF - FILT_LEN - 4);
            end else begin
                tick(HALF);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        tick(20);
    endtask

    function automatic logic [10:0] frame(input logic [7:0] b, input logic par, input logic stop);
        return {stop, par, b, 1'b0};
    endfunction

    task automatic send_good(input logic [7:0] b, input int glitch_at, input int glitch_len, input bit pop_at_push);
        send_bits(frame(b, ~^b, 1'b1), 11, glitch_at, glitch_len, pop_at_push);
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else                      model_ovf = 1'b1;
    endtask

    task automatic read_check(input string tag);
        logic [7:0] e;
        e = exp_q.pop_front();
        check({tag, "_valid"}, rd_valid, 1);
        check({tag, "_data"}, rd_data, e);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        check({tag, "_level_after"}, level, exp_q.size());
    endtask

    task automatic check_state(input string tag);
        check({tag, "_level"}, level, exp_q.size());
        check({tag, "_valid"}, rd_valid, exp_q.size() != 0);
        check({tag, "_ovf"}, ovf, model_ovf);
        check({tag, "_par_err_cnt"}, par_cnt, exp_par);
        check({tag, "_frm_err_cnt"}, frm_cnt, exp_frm);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick(3);
        exp_q.delete();
        model_ovf = 1'b0;
        rst = 1'b1;
        tick(2);
    endtask

    initial begin
        tick(3);
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_level", level, 0);
        check("rst_par_err", par_err, 0);
        check("rst_frm_err", frm_err, 0);
        check("rst_ovf", ovf, 0);
        rst = 1'b1;
        tick(5);

        // Single good byte, then read it out.
        send_good(8'h1C, -1, 0, 1'b0);
        check_state("good_1c");
        read_check("rd_1c");
        check_state("after_rd_1c");

        // Parity failure, then bad stop bit with good parity.
        send_bits(frame(8'h1C, 1'b1, 1'b1), 11, -1, 0, 1'b0);
        exp_par++;
        check_state("par_err");
        send_bits(frame(8'hF0, 1'b1, 1'b0), 11, -1, 0, 1'b0);
        exp_frm++;
        check_state("stop_err");

        // Truncated frame times out; the next frame must still be received.
        send_bits(frame(8'h0F, 1'b1, 1'b1), 4, -1, 0, 1'b0);
        tick(TIMEOUT_CYC + 10);
        exp_frm++;
        check_state("timeout");
        send_good(8'hF0, -1, 0, 1'b0);
        check_state("after_timeout");
        read_check("rd_f0");

        // Overflow on the fifth byte.
        for (int i = 1; i <= 5; i++) send_good(8'(i * 8'h11), -1, 0, 1'b0);
        check_state("ovf_set");
        for (int i = 0; i < 4; i++) read_check("rd_ovf");
        check_state("ovf_drained");
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        model_ovf = 1'b0;
        check_state("ovf_clr");

        // Fifth push coincides with a pop: no overflow.
        for (int i = 1; i <= 4; i++) send_good(8'(i * 8'h11), -1, 0, 1'b0);
        send_good(8'h55, -1, 0, 1'b1);
        check_state("push_pop_full");
        for (int i = 0; i < 4; i++) read_check("rd_pp");

        // Short clock glitch is filtered out.
        send_good(8'h1C, 5, FILT_LEN - 2, 1'b0);
        check_state("short_glitch");
        read_check("rd_glitch");

        // Long glitch inserts an extra bit; parity bit lands in the stop slot.
        send_bits(frame(8'h1C, 1'b0, 1'b1), 11, 5, FILT_LEN + 2, 1'b0);
        exp_frm++;
        check_state("long_glitch");

        // Reset in the middle of a frame discards it.
        send_bits(frame(8'hA5, 1'b1, 1'b1), 6, -1, 0, 1'b0);
        do_reset();
        send_good(8'h5A, -1, 0, 1'b0);
        check_state("after_mid_rst");
        check("mid_rst_data", rd_data, 8'h5A);

        check("err_overlap", both_cnt, 0);
        check("err_pulse_width", wide_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
